// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the decode-stage hazard scoreboard.
package hazard_scoreboard_pkg;
  localparam int MAX_PENDING = 4;
  localparam int CNT_W       = 3;
  localparam int AW          = 5;

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} sb_state_e;

  typedef struct packed {
    logic          dec_valid;
    logic          dec_rden1;
    logic [AW-1:0] dec_raddr1;
    logic          dec_rden2;
    logic [AW-1:0] dec_raddr2;
    logic          dec_wren;
    logic [AW-1:0] dec_waddr;
    logic          dec_long;
    logic          dec_fence;
    logic          flush;
    logic          wb_valid;
    logic [AW-1:0] wb_waddr;
  } hazard_scoreboard_in_type;

  typedef struct packed {
    logic issue;
    logic stall;
    logic bypass1;
    logic bypass2;
  } hazard_scoreboard_out_type;

  // Writeback completion for register r this cycle; x0 never completes.
  function automatic logic wb_clr(input logic wb_valid, input logic [AW-1:0] wb_waddr,
                                  input logic [AW-1:0] r);
    return wb_valid && (wb_waddr == r) && (r != '0);
  endfunction
endpackage

// File: rtl/hazard_scoreboard_regfile.sv
// Pending-destination bits and outstanding-op counter for long-latency ops.
module scoreboard_regfile #(
  parameter int MAX_PENDING = 4,
  parameter int CNT_W       = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             set_en,
  input  logic [4:0]       set_addr,
  input  logic             clr_en,
  input  logic [4:0]       clr_addr,
  output logic [31:0]      pending,
  output logic [CNT_W-1:0] count,
  output logic             busy
);
  logic [31:1]      pend_q, pend_next;
  logic             set_hit, clr_hit;
  logic [CNT_W-1:0] count_next;

  assign pending = {pend_q, 1'b0};

  // Completions for registers not pending are dropped so the count cannot underflow.
  assign set_hit = set_en && (set_addr != 5'd0);
  assign clr_hit = clr_en && (clr_addr != 5'd0) && pending[clr_addr];

  always_comb begin
    pend_next = pend_q;
    for (int i = 1; i < 32; i++) begin
      // Set is applied after clear so a same-register set/clear keeps the bit.
      if (clr_hit && clr_addr == 5'(i)) pend_next[i] = 1'b0;
      if (set_hit && set_addr == 5'(i)) pend_next[i] = 1'b1;
    end
  end

  assign count_next = count + CNT_W'(set_hit) - CNT_W'(clr_hit);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_q <= '0;
      count  <= '0;
      busy   <= 1'b0;
    end else begin
      pend_q <= pend_next;
      count  <= count_next;
      busy   <= (count_next != '0);
    end
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage issue controller: RAW/WAW/full stalls, wb bypass steering, fence drain.
module hazard_scoreboard #(
  parameter int MAX_PENDING = hazard_scoreboard_pkg::MAX_PENDING,
  parameter int CNT_W       = hazard_scoreboard_pkg::CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             dec_valid,
  input  logic             dec_rden1,
  input  logic [4:0]       dec_raddr1,
  input  logic             dec_rden2,
  input  logic [4:0]       dec_raddr2,
  input  logic             dec_wren,
  input  logic [4:0]       dec_waddr,
  input  logic             dec_long,
  input  logic             dec_fence,
  input  logic             flush,
  input  logic             wb_valid,
  input  logic [4:0]       wb_waddr,
  output logic             issue,
  output logic             stall,
  output logic             bypass1,
  output logic             bypass2,
  output logic [CNT_W-1:0] pending_cnt,
  output logic             busy
);
  import hazard_scoreboard_pkg::*;

  hazard_scoreboard_in_type  in_s;
  hazard_scoreboard_out_type out_s;
  sb_state_e                 state, state_next;
  logic [31:0]               pending;
  logic [CNT_W-1:0]          count;
  logic clr1, clr2, clrw, raw1, raw2, waw, full, hazard, go, fence_ok, last_done;

  always_comb begin
    in_s            = '0;
    in_s.dec_valid  = dec_valid;
    in_s.dec_rden1  = dec_rden1;
    in_s.dec_raddr1 = dec_raddr1;
    in_s.dec_rden2  = dec_rden2;
    in_s.dec_raddr2 = dec_raddr2;
    in_s.dec_wren   = dec_wren;
    in_s.dec_waddr  = dec_waddr;
    in_s.dec_long   = dec_long;
    in_s.dec_fence  = dec_fence;
    in_s.flush      = flush;
    in_s.wb_valid   = wb_valid;
    in_s.wb_waddr   = wb_waddr;
  end

  // A register completing this cycle is not a hazard; its value comes off the wb bus.
  assign clr1 = wb_clr(in_s.wb_valid, in_s.wb_waddr, in_s.dec_raddr1);
  assign clr2 = wb_clr(in_s.wb_valid, in_s.wb_waddr, in_s.dec_raddr2);
  assign clrw = wb_clr(in_s.wb_valid, in_s.wb_waddr, in_s.dec_waddr);

  assign raw1   = in_s.dec_rden1 && pending[in_s.dec_raddr1] && !clr1;
  assign raw2   = in_s.dec_rden2 && pending[in_s.dec_raddr2] && !clr2;
  assign waw    = in_s.dec_wren  && pending[in_s.dec_waddr]  && !clrw;
  assign full   = in_s.dec_long && in_s.dec_wren &&
                  (count == CNT_W'(MAX_PENDING)) && !in_s.wb_valid;
  assign hazard = raw1 || raw2 || waw || full;
  assign go     = in_s.dec_valid && !in_s.flush;

  assign last_done = (count == CNT_W'(1)) && in_s.wb_valid;
  assign fence_ok  = (count == '0) || last_done;

  always_comb begin
    out_s         = '0;
    state_next    = state;
    out_s.bypass1 = in_s.dec_rden1 && clr1;
    out_s.bypass2 = in_s.dec_rden2 && clr2;
    case (state)
      RUN: begin
        if (in_s.dec_fence) begin
          if (fence_ok) begin
            out_s.issue = go;
          end else begin
            out_s.stall = go;
            if (go) state_next = DRAIN;
          end
        end else begin
          out_s.stall = go && hazard;
          out_s.issue = go && !hazard;
        end
      end
      DRAIN: begin
        // The fence re-issues from RUN the cycle after the last completion.
        out_s.stall = in_s.dec_valid;
        if (in_s.flush || last_done) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_next;
  end

  scoreboard_regfile #(.MAX_PENDING(MAX_PENDING), .CNT_W(CNT_W)) u_regfile (
    .clock    (clock),
    .reset    (reset),
    .set_en   (out_s.issue && in_s.dec_long && in_s.dec_wren),
    .set_addr (in_s.dec_waddr),
    .clr_en   (in_s.wb_valid),
    .clr_addr (in_s.wb_waddr),
    .pending  (pending),
    .count    (count),
    .busy     (busy)
  );

  assign issue       = out_s.issue;
  assign stall       = out_s.stall;
  assign bypass1     = out_s.bypass1;
  assign bypass2     = out_s.bypass2;
  assign pending_cnt = count;
endmodule
